// File: rtl/sample_packetizer_if.sv
// AXI-Stream style handshake bundle shared by the sample input and the packet output.
interface sample_packetizer_if #(
    parameter int unsigned DataWidth = 32
) ();
    logic                 tvalid;
    logic                 tready;
    logic [DataWidth-1:0] tdata;
    logic                 tlast;

    modport master (
        output tvalid,
        output tdata,
        output tlast,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/sample_packetizer.sv
// Sample packetizer: slices a never-stalling ADC stream into fixed-length packets
// and buffers them in a small FIFO towards a DMA engine.
module sample_packetizer #(
    parameter int unsigned C_AXIS_TDATA_WIDTH = 32,
    parameter int unsigned C_FIFO_DEPTH       = 16   // power of two, at least 2
) (
    input  logic                axis_aclk,
    input  logic                axis_areset,
    input  logic                enable,
    input  logic [15:0]         packet_words,
    sample_packetizer_if.slave  s00_axis,
    sample_packetizer_if.master m00_axis,
    output logic [15:0]         dropped_count,
    output logic [31:0]         packet_count,
    output logic                busy
);
    localparam int unsigned PtrW = $clog2(C_FIFO_DEPTH);
    localparam int unsigned CntW = C_FIFO_DEPTH + 1;
    localparam logic [CntW-1:0] FullCnt = CntW'(C_FIFO_DEPTH);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e                      state_q;
    logic                        s_ready_q;
    logic [PtrW-1:0]             wr_ptr_q;
    logic [PtrW-1:0]             rd_ptr_q;
    logic [CntW-1:0]             count_q;
    logic [15:0]                 len_q;
    logic [15:0]                 word_cnt_q;
    logic [C_AXIS_TDATA_WIDTH:0] mem_q [C_FIFO_DEPTH];   // {tlast, tdata}

    logic                        accept;
    logic                        fifo_empty;
    logic                        fifo_full;
    logic                        pop;
    logic                        run_word;
    logic                        push;
    logic                        last_word;
    logic [15:0]                 len_next;
    logic [C_AXIS_TDATA_WIDTH:0] head;

    // Handshake decode and packet-boundary detection.
    always_comb begin
        accept     = s00_axis.tvalid && s_ready_q;
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == FullCnt);
        pop        = !fifo_empty && m00_axis.tready;
        run_word   = (state_q == StRun) && accept;
        // A full FIFO can still take a word when the head leaves in the same cycle.
        push       = run_word && (!fifo_full || pop);
        last_word  = (word_cnt_q == len_q - 16'd1);
        len_next   = (packet_words == 16'd0) ? 16'd1 : packet_words;
        head       = mem_q[rd_ptr_q];
    end

    // FIFO storage; no reset needed since reads are gated by occupancy.
    always_ff @(posedge axis_aclk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {last_word, s00_axis.tdata};
        end
    end

    // Control FSM, FIFO pointers and statistics counters.
    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            state_q       <= StIdle;
            s_ready_q     <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            len_q         <= '0;
            word_cnt_q    <= '0;
            dropped_count <= '0;
            packet_count  <= '0;
        end else begin
            s_ready_q <= 1'b1;
            count_q   <= count_q + CntW'(push) - CntW'(pop);
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    if (enable) begin
                        state_q    <= StRun;
                        len_q      <= len_next;
                        word_cnt_q <= '0;
                    end
                end
                StRun: begin
                    if (run_word) begin
                        if (!push && dropped_count != 16'hFFFF) begin
                            dropped_count <= dropped_count + 16'd1;
                        end
                        if (last_word) begin
                            word_cnt_q <= '0;
                            if (push) begin
                                packet_count <= packet_count + 32'd1;
                            end
                            if (!enable) begin
                                state_q <= StIdle;
                            end else begin
                                len_q <= len_next;
                            end
                        end else begin
                            word_cnt_q <= word_cnt_q + 16'd1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign s00_axis.tready = s_ready_q;
    assign m00_axis.tvalid = !fifo_empty;
    assign m00_axis.tdata  = fifo_empty ? '0 : head[C_AXIS_TDATA_WIDTH-1:0];
    assign m00_axis.tlast  = !fifo_empty && head[C_AXIS_TDATA_WIDTH];
    assign busy            = (state_q == StRun);
endmodule

// File: tb/tb_sample_packetizer.sv
// Directed bench for sample_packetizer with a scoreboard of expected output words.
module tb_sample_packetizer;
    localparam int unsigned W = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] packet_words;
    logic [15:0] dropped_count;
    logic [31:0] packet_count;
    logic        busy;

    sample_packetizer_if #(.DataWidth(W)) s00_axis ();
    sample_packetizer_if #(.DataWidth(W)) m00_axis ();

    sample_packetizer #(
        .C_AXIS_TDATA_WIDTH(W),
        .C_FIFO_DEPTH      (16)
    ) dut (
        .axis_aclk    (clk),
        .axis_areset  (rst),
        .enable       (enable),
        .packet_words (packet_words),
        .s00_axis     (s00_axis),
        .m00_axis     (m00_axis),
        .dropped_count(dropped_count),
        .packet_count (packet_count),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [W:0]  sb_q [$];   // {tlast, tdata}
    logic        stall_q = 1'b0;
    logic [W-1:0] stall_data;
    logic        stall_last;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on each handshake and checks stall stability.
    always @(negedge clk) begin
        if (!rst) begin
            if (stall_q) begin
                chk("stall_valid", 64'(m00_axis.tvalid), 64'd1);
                chk("stall_data", 64'(m00_axis.tdata), 64'(stall_data));
                chk("stall_last", 64'(m00_axis.tlast), 64'(stall_last));
            end
            if (m00_axis.tvalid && m00_axis.tready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL unexpected_out: observed=%0h expected=none",
                           {m00_axis.tlast, m00_axis.tdata});
                end else begin
                    chk("out_word", 64'({m00_axis.tlast, m00_axis.tdata}), 64'(sb_q.pop_front()));
                end
            end
            stall_q    <= m00_axis.tvalid && !m00_axis.tready;
            stall_data <= m00_axis.tdata;
            stall_last <= m00_axis.tlast;
        end else begin
            stall_q <= 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one word for one cycle; expected words go to the scoreboard now.
    task automatic send(input logic [W-1:0] d, input bit exp_push, input bit exp_last);
        s00_axis.tvalid = 1'b1;
        s00_axis.tdata  = d;
        if (exp_push) sb_q.push_back({exp_last, d});
        tick();
        s00_axis.tvalid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        m00_axis.tready = 1'b1;
        while (sb_q.size() != 0 && n < 64) begin
            tick();
            n++;
        end
        tick();
        chk(tag, 64'(sb_q.size()), 64'd0);
        chk({tag, "_idle"}, 64'(m00_axis.tvalid), 64'd0);
    endtask

    initial begin
        rst             = 1'b1;
        enable          = 1'b0;
        packet_words    = 16'd4;
        s00_axis.tvalid = 1'b0;
        s00_axis.tdata  = '0;
        s00_axis.tlast  = 1'b0;
        m00_axis.tready = 1'b1;
        repeat (3) tick();

        chk("rst_s_ready", 64'(s00_axis.tready), 64'd0);
        chk("rst_m_valid", 64'(m00_axis.tvalid), 64'd0);
        chk("rst_m_last", 64'(m00_axis.tlast), 64'd0);
        chk("rst_m_data", 64'(m00_axis.tdata), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_dropped", 64'(dropped_count), 64'd0);
        chk("rst_packets", 64'(packet_count), 64'd0);

        rst = 1'b0;
        tick();
        chk("idle_s_ready", 64'(s00_axis.tready), 64'd1);
        send(32'hAA, 1'b0, 1'b0);   // discarded while idle
        chk("idle_no_write", 64'(m00_axis.tvalid), 64'd0);

        // Basic packets: len 4, output one cycle after input.
        enable = 1'b1;
        tick();
        chk("run_busy", 64'(busy), 64'd1);
        for (int i = 1; i <= 8; i++) begin
            send(W'(i), 1'b1, (i % 4) == 0);
            chk("latency_valid", 64'(m00_axis.tvalid), 64'd1);
            chk("latency_data", 64'(m00_axis.tdata), 64'(i));
        end
        tick();
        tick();
        chk("basic_packets", 64'(packet_count), 64'd2);

        // Overflow: 20 words into a stalled 16-deep FIFO.
        m00_axis.tready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            send(32'h100 + W'(i), i < 16, (i % 4) == 3);
        end
        chk("ovf_dropped", 64'(dropped_count), 64'd4);
        chk("ovf_packets", 64'(packet_count), 64'd6);
        chk("ovf_held", 64'(m00_axis.tvalid), 64'd1);
        drain("ovf_drain");

        // Graceful stop: enable falls after word 2, packet still completes.
        send(32'h201, 1'b1, 1'b0);
        send(32'h202, 1'b1, 1'b0);
        enable = 1'b0;
        send(32'h203, 1'b1, 1'b0);
        send(32'h204, 1'b1, 1'b1);
        chk("stop_busy", 64'(busy), 64'd0);
        for (int i = 1; i <= 4; i++) send(32'h300 + W'(i), 1'b0, 1'b0);
        drain("stop_drain");
        chk("stop_packets", 64'(packet_count), 64'd7);

        // Zero length behaves as one-word packets.
        packet_words = 16'd0;
        enable       = 1'b1;
        tick();
        for (int i = 1; i <= 5; i++) begin
            if (i == 5) enable = 1'b0;
            send(32'h400 + W'(i), 1'b1, 1'b1);
        end
        chk("zero_busy", 64'(busy), 64'd0);
        drain("zero_drain");
        chk("zero_packets", 64'(packet_count), 64'd12);

        // Random backpressure, len 3.
        packet_words = 16'd3;
        enable       = 1'b1;
        tick();
        begin
            int n = 0;
            int cyc = 0;
            while (n < 30) begin
                m00_axis.tready = ($urandom_range(0, 3) != 0);
                if (cyc % 2 == 0) begin
                    if (n == 29) enable = 1'b0;
                    send(32'h500 + W'(n), 1'b1, (n % 3) == 2);
                    n++;
                end else begin
                    tick();
                end
                cyc++;
            end
        end
        drain("bp_drain");
        chk("bp_dropped", 64'(dropped_count), 64'd4);
        chk("bp_packets", 64'(packet_count), 64'd22);

        // Mid-packet reset discards buffered and partial data.
        packet_words    = 16'd4;
        enable          = 1'b1;
        m00_axis.tready = 1'b0;
        tick();
        send(32'h601, 1'b0, 1'b0);
        send(32'h602, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        chk("mrst_m_valid", 64'(m00_axis.tvalid), 64'd0);
        chk("mrst_m_data", 64'(m00_axis.tdata), 64'd0);
        chk("mrst_m_last", 64'(m00_axis.tlast), 64'd0);
        chk("mrst_s_ready", 64'(s00_axis.tready), 64'd0);
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_packets", 64'(packet_count), 64'd0);
        chk("mrst_dropped", 64'(dropped_count), 64'd0);
        rst             = 1'b0;
        m00_axis.tready = 1'b1;
        tick();
        for (int i = 1; i <= 4; i++) begin
            if (i == 4) enable = 1'b0;
            send(32'h700 + W'(i), 1'b1, i == 4);
        end
        drain("fresh_drain");
        chk("fresh_packets", 64'(packet_count), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
